// File: rtl/icache_fetch.sv
// icache_fetch: set-associative instruction fetch cache with a single-line refill FSM.
// Two-wide issue pairing is compiled in only when ICACHE_DUAL_ISSUE_EN is defined.

module icache_way_match #(
    parameter int TAG_W = 52
) (
    input  logic             valid,
    input  logic [TAG_W-1:0] tag,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic [63:0]      beat_a,
    input  logic [63:0]      beat_b,
    output logic             hit,
    output logic [63:0]      sel_a,
    output logic [63:0]      sel_b
);
    // Miss ways drive zero so the top can OR all ways together.
    assign hit   = valid && (tag == lookup_tag);
    assign sel_a = hit ? beat_a : '0;
    assign sel_b = hit ? beat_b : '0;
endmodule

module icache_fetch #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic [63:0] pc,
    input  logic        flush,
    output logic [31:0] instr0,
    output logic [31:0] instr1,
    output logic        instr0_valid,
    output logic        instr1_valid,
    output logic [1:0]  pc_adv,
    output logic        miss,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    input  logic        mem_resp_last
);
    localparam int BEATS  = LINE_BYTES / 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 64 - OFF_W - IDX_W;
    localparam int LINE_W = 64 - OFF_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic [WAY_W-1:0]  way;
    } refill_t;

    state_t                       state_q, state_d;
    refill_t                      rf_q;
    logic [BEAT_W-1:0]            beat_q;
    logic                         flush_pend_q;
    logic [SETS-1:0][WAYS-1:0]    valid_q;
    logic [SETS-1:0][WAY_W-1:0]   rr_q;
    logic [TAG_W-1:0]             tag_q  [WAYS][SETS];
    logic [63:0]                  data_q [WAYS][SETS][BEATS];

    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [BEAT_W-1:0] beat0, beat1;
    logic [IDX_W-1:0]  line_idx;
    logic [TAG_W-1:0]  line_tag;

    assign pc_idx   = pc[OFF_W+IDX_W-1:OFF_W];
    assign pc_tag   = pc[63:OFF_W+IDX_W];
    assign beat0    = pc[OFF_W-1:3];
    assign beat1    = beat0 + 1'b1;
    assign line_idx = rf_q.line[IDX_W-1:0];
    assign line_tag = rf_q.line[LINE_W-1:IDX_W];

    // ---------------- lookup ----------------
    logic [WAYS-1:0]       way_hit;
    logic [WAYS-1:0][63:0] way_a, way_b;
    logic [63:0]           hit_a, hit_b;
    logic                  hit;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way_match #(.TAG_W(TAG_W)) u_match (
            .valid      (valid_q[pc_idx][w]),
            .tag        (tag_q[w][pc_idx]),
            .lookup_tag (pc_tag),
            .beat_a     (data_q[w][pc_idx][beat0]),
            .beat_b     (data_q[w][pc_idx][beat1]),
            .hit        (way_hit[w]),
            .sel_a      (way_a[w]),
            .sel_b      (way_b[w])
        );
    end

    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_a = hit_a | way_a[w];
            hit_b = hit_b | way_b[w];
        end
    end

    assign hit = |way_hit;

    logic lookup_hit, start_miss;
    logic [31:0] w0;

    assign lookup_hit = fetch_en && hit && (state_q == S_IDLE);
    assign start_miss = fetch_en && !hit && (state_q == S_IDLE);
    assign w0         = pc[2] ? hit_a[63:32] : hit_a[31:0];

    assign instr0       = lookup_hit ? w0 : '0;
    assign instr0_valid = lookup_hit;
    assign pc_adv       = !lookup_hit ? 2'd0 : (instr1_valid ? 2'd2 : 2'd1);

`ifdef ICACHE_DUAL_ISSUE_EN
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Control-flow, system and all-zero words always close the fetch group.
    function automatic logic ends_group(input logic [6:0] op);
        case (op)
            7'b0000000, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_IMM32, OP_AUIPC, OP_LUI, OP_REG, OP_REG32: return 1'b1;
            default:                                                      return 1'b0;
        endcase
    endfunction

    function automatic logic raw_hazard(input logic [31:0] i0, input logic [31:0] i1);
        logic [4:0] rd;
        logic       use1, use2;
        rd   = i0[11:7];
        use1 = 1'b0;
        use2 = 1'b0;
        case (i1[6:0])
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR:      use1 = 1'b1;
            OP_STORE, OP_REG, OP_REG32, OP_BRANCH: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            default: ;
        endcase
        return writes_rd(i0[6:0]) && (rd != 5'd0) &&
               ((use1 && (i1[19:15] == rd)) || (use2 && (i1[24:20] == rd)));
    endfunction

    logic [31:0] w1;
    logic        same_line;
    logic        unused_bits;

    assign w1           = pc[2] ? hit_b[31:0] : hit_a[63:32];
    assign same_line    = !(&pc[OFF_W-1:2]);
    assign instr1_valid = lookup_hit && same_line && !ends_group(w0[6:0]) && !raw_hazard(w0, w1);
    assign instr1       = instr1_valid ? w1 : '0;
    assign unused_bits  = ^{pc[1:0], hit_b[63:32]};
`else
    logic unused_bits;

    assign instr1_valid = 1'b0;
    assign instr1       = '0;
    assign unused_bits  = ^{pc[1:0], hit_b};
`endif

    // ---------------- victim selection ----------------
    logic [WAY_W-1:0] victim;
    logic             found;

    always_comb begin
        victim = rr_q[pc_idx];
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[pc_idx][w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0] p);
        return (p == WAY_W'(WAYS - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- refill FSM ----------------
    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        miss          = start_miss;
        case (state_q)
            S_IDLE: if (start_miss) state_d = S_REQ;
            S_REQ: begin
                mem_req_valid = 1'b1;
                miss          = 1'b1;
                if (mem_req_ready) state_d = S_FILL;
            end
            S_FILL: begin
                miss = 1'b1;
                if (mem_resp_valid && mem_resp_last) state_d = S_DONE;
            end
            S_DONE: begin
                miss    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req_addr = {rf_q.line, {OFF_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rf_q         <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            rr_q         <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start_miss) begin
                    rf_q.line <= pc[63:OFF_W];
                    rf_q.way  <= victim;
                end
                S_FILL: if (mem_resp_valid) beat_q <= beat_q + 1'b1;
                S_DONE: begin
                    beat_q         <= '0;
                    rr_q[line_idx] <= rr_next(rr_q[line_idx]);
                    if (!flush_pend_q) valid_q[line_idx][rf_q.way] <= 1'b1;
                end
                default: ;
            endcase
            // A flush seen while the refill is in flight must keep DONE from validating it.
            if (flush && (state_q == S_REQ || state_q == S_FILL)) flush_pend_q <= 1'b1;
            else if (state_q == S_DONE)                           flush_pend_q <= 1'b0;
            if (flush) valid_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_FILL && mem_resp_valid) data_q[rf_q.way][line_idx][beat_q] <= mem_resp_data;
        if (state_q == S_DONE) tag_q[rf_q.way][line_idx] <= line_tag;
    end
endmodule

// File: doc/icache_fetch.md
ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 Parameter WAYS, 2, associativity; power of two, 1..8.
REQ-002 Parameter SETS, 64, sets per way; power of two.
REQ-003 Parameter LINE_BYTES, 64, line size; power of two, 16..128; refilled as LINE_BYTES/8 64-bit beats.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fetch_en  in  1  fetch request for pc this cycle.
REQ-007 pc  in  64  fetch address; bits [1:0] ignored.
REQ-008 flush  in  1  invalidate every line.
REQ-009 instr0, instr1  out  32 each  instruction at pc and pc+4.
REQ-010 instr0_valid, instr1_valid  out  1 each  slot valid qualifiers.
REQ-011 pc_adv  out  2  PC advance: 0 stall, 1 +4, 2 +8.
REQ-012 miss  out  1  high while a refill is outstanding or starting.
REQ-013 mem_req_valid  out  1; mem_req_ready  in  1; mem_req_addr  out  64, line-aligned refill address.
REQ-014 mem_resp_valid  in  1; mem_resp_data  in  64; mem_resp_last  in  1  refill beats, in ascending address order.

Function
REQ-015 Lookup combinational: hit when any way of set pc[idx] is valid with matching tag; instr0 = word pc[2] of the hit beat.
REQ-016 Hit with fetch_en: instr0_valid=1, pc_adv=1 or 2, miss=0, same cycle.
REQ-017 instr1_valid=1 only if: DUAL_ISSUE_EN defined, slot 0 valid, pc+4 in same line, slot 0 opcode not 0000000/1100011/1100111/1101111/1110011, and no RAW hazard; then pc_adv=2.
REQ-018 RAW hazard: slot 0 opcode writes rd (0000011, 0010011, 0011011, 0010111, 0110111, 0110011, 0111011), rd!=0, and rd equals slot 1 rs1 (I-type/JALR) or rs1/rs2 (S/R/B-type).
REQ-019 Miss with fetch_en in IDLE: miss=1, valids=0, pc_adv=0; FSM latches line address and victim way.
REQ-020 FSM states IDLE, REQ, FILL, DONE; IDLE->REQ on miss; REQ->FILL on mem_req_valid&&mem_req_ready; FILL->DONE on beat with mem_resp_last; DONE->IDLE after one cycle.
REQ-021 mem_req_valid held high with stable mem_req_addr throughout REQ until ready.
REQ-022 FILL writes each beat to a 0-based beat counter slot of the victim line; counter wraps to 0 at DONE.
REQ-023 DONE sets valid and tag of victim; line hits on the following IDLE cycle.
REQ-024 Victim: lowest-index invalid way; else per-set round-robin pointer, advanced modulo WAYS on each fill.
REQ-025 fetch_en low: valids=0, pc_adv=0, no refill started; an in-flight refill completes.
REQ-026 pc changing during refill does not abort it; the latched line is still filled.
REQ-027 flush: all valid bits cleared next edge; during REQ/FILL the refill drains, DONE does not set valid.
REQ-028 flush and a hit in the same cycle: outputs reflect pre-flush state.
REQ-029 Beat with mem_resp_valid outside FILL ignored.

Reset
REQ-030 reset: FSM=IDLE, all valid bits=0, round-robin pointers=0, beat counter=0; next-edge outputs: mem_req_valid=0, miss=0, valids=0, pc_adv=0.
REQ-031 reset mid-REQ/FILL abandons refill; remaining responses fall under REQ-029.

Configuration
REQ-032 Macro ICACHE_DUAL_ISSUE_EN: defined -> REQ-017/018 pairing active; undefined -> instr1_valid=0, instr1=0, pc_adv never 2.

Verification
REQ-033 Cold miss pc=0x1000, ready on 2nd REQ cycle, 8 beats -> mem_req_addr=0x1000, DONE then hit, instr0=beat0[31:0], pc_adv=2 when pair legal.
REQ-034 Hit pc=0x1004 (pc[2]=1, word 0x00A00093 addi x1) followed by 0x00108133 add x2,x1,x1 -> instr1_valid=0, pc_adv=1.
REQ-035 pc=0x103C (last word of line) on hit -> instr1_valid=0, pc_adv=1.
REQ-036 WAYS=2: fill 3 lines mapping to set 0 -> third fill replaces way 0, first line misses again.
REQ-037 flush asserted at 3rd FILL beat -> refill drains, refetch of same pc misses again.
REQ-038 reset asserted mid-FILL -> next cycle mem_req_valid=0, miss=0; stray beats produce no hit.
